pool_word_packer: RTL and testbench
===================================

# pool_word_packer

Downstream stage of the max-pooling unit. Collects the 16-bit pooled results emitted one per `i_valid` pulse, packs them four at a time into 64-bit words (lane 0 = bits [15:0], first-arriving value), and buffers the words in a small FIFO toward a ready/valid consumer. It closes words early at row end with zero fill, and tags row-end and frame-end words. The pooling unit has no backpressure input, so this block absorbs consumer stalls and flags overflow when it cannot.

## Interface
- `DATA_W`, 16, width of one pooled value
- `LANES`, 4, values per output word; output width is `DATA_W*LANES`
- `ROW_LEN`, 20, pooled values per output row (1..255)
- `ROWS`, 20, rows per frame (1..255)
- `FIFO_DEPTH`, 8, word FIFO entries (power of two, ≥2)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `i_valid`  in  1  pooled value present this cycle; cannot be stalled
- `i_data`  in  16  pooled value
- `o_valid`  out  1  FIFO head word available
- `o_ready`  in  1  consumer accepts head word
- `o_data`  out  64  packed word
- `o_row_end`  out  1  head word is last word of a row
- `o_last`  out  1  head word is last word of a frame
- `frame_done`  out  1  one-cycle pulse when `o_last` word transfers
- `overflow`  out  1  sticky: a word was dropped because FIFO was full

## Operation
- Counters: `lane_idx` (0..LANES-1), `col_cnt` (0..ROW_LEN-1), `row_cnt` (0..ROWS-1).
- On `i_valid`: write `i_data` into the staging register at lane `lane_idx`; advance `col_cnt`, wrapping to 0 at ROW_LEN-1 and then advancing `row_cnt`, which wraps to 0 at ROWS-1.
- Word close occurs when `lane_idx==LANES-1` or `col_cnt==ROW_LEN-1`. On close, push {staging with the current value merged, lanes above `lane_idx` forced to 0, row_end, last}. `lane_idx` returns to 0 and the staging register clears.
- Tag rules: row_end=1 iff `col_cnt==ROW_LEN-1`; last=1 iff row_end and `row_cnt==ROWS-1`.
- FIFO push is accepted iff not full, or a pop occurs in the same cycle. Otherwise the word is dropped, `overflow` is set to 1, and it stays 1 until reset. Counters advance regardless, so frame alignment is kept.
- Pop on `o_valid && o_ready`. `frame_done` is asserted the cycle after a pop whose last tag is 1.
- `i_valid` with FIFO empty and `o_ready=1` still goes through the FIFO. There is no bypass.

## Timing
- Reset (async assert, sync release) clears these outputs: `o_valid`=0, `o_data`=0, `o_row_end`=0, `o_last`=0, `frame_done`=0, `overflow`=0. It also clears all counters, the staging register and the FIFO pointers. A partially filled word is discarded.
- Latency: if the closing `i_valid` is at edge N, `o_valid`=1 with that word from edge N+1.
- `o_data`/`o_row_end`/`o_last` hold stable while `o_valid && !o_ready`. When `o_valid`=0 they are 0.
- Throughput: one word per cycle out, in steady state.
- Simultaneous push and pop while full: both happen, occupancy is unchanged, and there is no overflow.
- Simultaneous push and pop while empty: the pop is not possible (`o_valid`=0). The push lands, and `o_valid` rises next cycle.
- ROW_LEN a multiple of LANES: no zero-filled words. LANES=4, ROW_LEN=6: word 2 of each row has lanes 2,3 = 0.

## Structure
- Shared package `pool_pkg` holds:
  - `POOL_DATA_W`=16 and `POOL_LANES`=4
  - `pool_word_t` (packed 64-bit)
  - `pool_tag_t` struct {row_end, last}
- Sub-module `pool_word_fifo`: synchronous show-ahead FIFO with width 66 and parameter `FIFO_DEPTH`. It exposes full, empty, push, pop and the head word. The packer holds the counters, staging and overflow logic.

## Test plan
- ROW_LEN=4, ROWS=2, `o_ready`=1. Input 1,2,3,4,5,6,7,8 on consecutive cycles. Expect two words:
  - `0x0004_0003_0002_0001` with row_end=1, last=0
  - `0x0008_0007_0006_0005` with row_end=1, last=1
  - `frame_done` pulses once.
- ROW_LEN=6, ROWS=1, `o_ready`=1. Input 0x10..0x15. Expect:
  - `0x0013_0012_0011_0010`, row_end=0
  - `0x0000_0000_0015_0014`, row_end=1, last=1
- FIFO_DEPTH=8, `o_ready`=0. Push 9 full words (36 values). Expect:
  - `o_valid`=1 with the first word stable throughout
  - `overflow` rises on the 9th close and stays 1
  - with `o_ready`=1 afterwards, exactly 8 words drain, in order
- FIFO full, `o_ready`=1 in the cycle a new word closes. Expect push and pop together, occupancy stays 8, `overflow`=0.
- Assert `rst`=0 after 2 of 4 lanes are filled and 3 words are queued. Expect:
  - all outputs 0 immediately (asynchronous)
  - after release, input 0xA,0xB,0xC,0xD gives `0x000D_000C_000B_000A` as the first word
- Random `i_valid` (50%) and random `o_ready` (70%) over 10 frames with ROW_LEN=20, ROWS=20. Check against a scoreboard model:
  - word content and tags
  - 100 words per frame
  - 10 `frame_done` pulses
  - `overflow`=0

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and constants for the max-pooling output path.
// Word layout: lane 0 occupies the least-significant DATA_W bits.
package pool_pkg;

  localparam int POOL_DATA_W = 16;
  localparam int POOL_LANES  = 4;
  localparam int POOL_WORD_W = POOL_DATA_W * POOL_LANES;
  localparam int POOL_CNT_W  = 8;

  typedef logic [POOL_WORD_W-1:0] pool_word_t;

  typedef struct packed {
    logic row_end;
    logic last;
  } pool_tag_t;

  // FIFO entry layout: {tag, word}
  typedef struct packed {
    pool_tag_t  tag;
    pool_word_t data;
  } pool_entry_t;

endpackage

// File: rtl/pool_word_fifo.sv
// Show-ahead word FIFO: the head entry is visible combinationally whenever not empty.
// A push into a full FIFO lands only when a pop happens in the same cycle.
module pool_word_fifo #(
  parameter int WIDTH      = 66,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB separates full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/pool_word_packer.sv
// Packs pooled values LANES-at-a-time into words, closing early at row end with
// zero fill, and queues tagged words toward a ready/valid consumer.
module pool_word_packer
  import pool_pkg::*;
#(
  parameter int DATA_W     = POOL_DATA_W,
  parameter int LANES      = POOL_LANES,
  parameter int ROW_LEN    = 20,
  parameter int ROWS       = 20,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic [DATA_W-1:0]       i_data,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [DATA_W*LANES-1:0] o_data,
  output logic                    o_row_end,
  output logic                    o_last,
  output logic                    frame_done,
  output logic                    overflow
);

  localparam int WORD_W = DATA_W * LANES;
  localparam int ENT_W  = WORD_W + $bits(pool_tag_t);
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;

  logic [LW-1:0]                 r_lane_idx;
  logic [POOL_CNT_W-1:0]         r_col_cnt;
  logic [POOL_CNT_W-1:0]         r_row_cnt;
  logic [LANES-1:0][DATA_W-1:0]  r_stage;
  logic                          r_frame_done;
  logic                          r_overflow;

  logic [LANES-1:0][DATA_W-1:0]  w_word;
  pool_tag_t                     w_tag;
  pool_tag_t                     w_head_tag;
  logic [WORD_W-1:0]             w_head_word;
  logic [ENT_W-1:0]              w_head_ent;
  logic                          w_col_end;
  logic                          w_row_end;
  logic                          w_lane_end;
  logic                          w_close;
  logic                          w_pop;
  logic                          w_push;
  logic                          w_full;
  logic                          w_empty;

  assign w_col_end  = (r_col_cnt == POOL_CNT_W'(ROW_LEN - 1));
  assign w_row_end  = (r_row_cnt == POOL_CNT_W'(ROWS - 1));
  assign w_lane_end = (r_lane_idx == LW'(LANES - 1));
  assign w_close    = i_valid && (w_col_end || w_lane_end);
  assign w_pop      = !w_empty && o_ready;
  assign w_push     = w_close && (!w_full || w_pop);

  assign w_tag.row_end = w_col_end;
  assign w_tag.last    = w_col_end && w_row_end;

  // Closing word: current value merged at lane_idx, everything above forced to 0.
  always_comb begin
    w_word = r_stage;
    for (int l = 0; l < LANES; l++) begin
      if (l == int'(r_lane_idx))     w_word[l] = i_data;
      else if (l > int'(r_lane_idx)) w_word[l] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stage    <= '0;
      r_lane_idx <= '0;
    end else if (i_valid) begin
      if (w_close) begin
        r_stage    <= '0;
        r_lane_idx <= '0;
      end else begin
        r_stage[r_lane_idx] <= i_data;
        r_lane_idx          <= r_lane_idx + 1'b1;
      end
    end
  end

  // Position counters advance on every value, even when its word is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col_cnt <= '0;
      r_row_cnt <= '0;
    end else if (i_valid) begin
      if (w_col_end) begin
        r_col_cnt <= '0;
        r_row_cnt <= w_row_end ? '0 : r_row_cnt + 1'b1;
      end else begin
        r_col_cnt <= r_col_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_close && !w_push) r_overflow <= 1'b1;
      r_frame_done <= w_pop && w_head_tag.last;
    end
  end

  pool_word_fifo #(
    .WIDTH      (ENT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({w_tag, w_word}),
    .i_pop   (w_pop),
    .o_head  (w_head_ent),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {w_head_tag, w_head_word} = w_head_ent;

  // Head is masked so outputs read 0 whenever nothing is queued.
  assign o_valid    = !w_empty;
  assign o_data     = w_empty ? '0 : w_head_word;
  assign o_row_end  = !w_empty && w_head_tag.row_end;
  assign o_last     = !w_empty && w_head_tag.last;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_pool_word_packer.sv
// Scoreboard bench: the driver predicts words from (index mod ROW_LEN) arithmetic,
// a negedge monitor pops and compares on every transfer.
module tb_pool_word_packer;

  localparam int DW  = 16;
  localparam int LN  = 4;
  localparam int RL  = 10;
  localparam int RW  = 3;
  localparam int FD  = 8;
  localparam int WPR = (RL + LN - 1) / LN;

  logic              clk     = 1'b0;
  logic              rst     = 1'b0;
  logic              i_valid = 1'b0;
  logic              o_ready = 1'b0;
  logic [DW-1:0]     i_data  = '0;
  logic              o_valid;
  logic              o_row_end;
  logic              o_last;
  logic              frame_done;
  logic              overflow;
  logic [DW*LN-1:0]  o_data;

  pool_word_packer #(
    .DATA_W(DW), .LANES(LN), .ROW_LEN(RL), .ROWS(RW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .o_row_end(o_row_end), .o_last(o_last),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW*LN-1:0] d;
    bit               re;
    bit               la;
  } exp_t;

  exp_t                 exp_q[$];
  exp_t                 mon_e;
  logic [LN-1:0][DW-1:0] acc = '0;
  int                   k, n_chk, n_fail, n_pop, n_fd;
  bit                   exp_ovf, fd_exp, prev_stall;
  logic [DW*LN-1:0]     prev_d;
  bit                   rv, rr;
  int                   n0, f0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; the model decides acceptance from its own occupancy.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit rdy);
    bit   drop;
    exp_t e;
    int   col, row;
    drop    = 1'b0;
    i_valid = v;
    i_data  = d;
    o_ready = rdy;
    if (v) begin
      col = k % RL;
      row = (k / RL) % RW;
      acc[col % LN] = d;
      if (col == RL - 1 || col % LN == LN - 1) begin
        e.d  = acc;
        e.re = (col == RL - 1);
        e.la = (col == RL - 1) && (row == RW - 1);
        if (exp_q.size() < FD || (exp_q.size() > 0 && rdy)) exp_q.push_back(e);
        else drop = 1'b1;
        acc = '0;
      end
      k = (k + 1) % (RL * RW);
    end
    @(posedge clk);
    #1;
    if (drop) exp_ovf = 1'b1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      step(1'b0, '0, 1'b1);
      t++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    step(1'b0, '0, 1'b1);
    check("drain_valid", 64'(o_valid), 64'(0));
  endtask

  task automatic finish_frame(input bit rdy);
    while (k != 0) step(1'b1, 16'($urandom), rdy);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      fd_exp     = 1'b0;
      prev_stall = 1'b0;
    end else begin
      check("frame_done", 64'(frame_done), 64'(fd_exp));
      check("overflow", 64'(overflow), 64'(exp_ovf));
      if (frame_done) n_fd++;
      if (prev_stall) check("hold_data", o_data, prev_d);
      if (!o_valid) begin
        check("idle_data", o_data, 64'(0));
        check("idle_tags", 64'({o_row_end, o_last}), 64'(0));
      end
      fd_exp = 1'b0;
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_word", 64'(o_valid), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          check("word_data", o_data, mon_e.d);
          check("word_row_end", 64'(o_row_end), 64'(mon_e.re));
          check("word_last", 64'(o_last), 64'(mon_e.la));
          fd_exp = mon_e.la;
          n_pop++;
        end
      end
      prev_stall = o_valid && !o_ready;
      prev_d     = o_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_data", o_data, 64'(0));
    check("rst_tags", 64'({o_row_end, o_last}), 64'(0));
    check("rst_flags", 64'({frame_done, overflow}), 64'(0));
    rst = 1'b1;
    step(1'b0, '0, 1'b1);

    // Latency and zero fill at row end
    for (int i = 0; i < 4; i++) step(1'b1, 16'(16'h10 + i), 1'b1);
    check("lat_valid", 64'(o_valid), 64'(1));
    check("lat_data", o_data, 64'h0013_0012_0011_0010);
    for (int i = 4; i < 10; i++) step(1'b1, 16'(16'h10 + i), 1'b1);
    check("fill_data", o_data, 64'h0000_0000_0019_0018);
    check("fill_tags", 64'({o_row_end, o_last}), 64'b10);
    finish_frame(1'b1);
    drain();
    check("frame1_fd", 64'(n_fd), 64'(1));

    // Full FIFO with simultaneous push and pop
    n0 = n_pop;
    for (int i = 0; i < RL * RW - 1; i++) step(1'b1, 16'($urandom), 1'b0);
    step(1'b1, 16'($urandom), 1'b1);
    step(1'b0, '0, 1'b0);
    check("full_pp_valid", 64'(o_valid), 64'(1));
    drain();
    check("full_pp_words", 64'(n_pop - n0), 64'(9));

    // Overflow: ninth word dropped, eight drain in order
    n0 = n_pop;
    for (int i = 0; i < RL * RW; i++) step(1'b1, 16'($urandom), 1'b0);
    repeat (3) step(1'b0, '0, 1'b0);
    check("ovf_set", 64'(overflow), 64'(1));
    drain();
    check("ovf_words", 64'(n_pop - n0), 64'(8));
    check("ovf_sticky", 64'(overflow), 64'(1));

    // Reset with 3 words queued and 2 lanes staged
    for (int i = 0; i < 12; i++) step(1'b1, 16'($urandom), 1'b0);
    #2;
    rst = 1'b0;
    i_valid = 1'b0;
    #1;
    check("arst_valid", 64'(o_valid), 64'(0));
    check("arst_data", o_data, 64'(0));
    check("arst_tags", 64'({o_row_end, o_last}), 64'(0));
    check("arst_flags", 64'({frame_done, overflow}), 64'(0));
    exp_q.delete();
    acc = '0;
    k = 0;
    exp_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 16'(16'hA + i), 1'b1);
    check("post_rst_data", o_data, 64'h000D_000C_000B_000A);
    finish_frame(1'b1);
    drain();

    // Random traffic over 10 frames
    n0 = n_pop;
    f0 = n_fd;
    for (int i = 0; i < 10 * RL * RW; ) begin
      rv = ($urandom_range(99) < 50);
      rr = ($urandom_range(99) < 70);
      step(rv, 16'($urandom), rr);
      if (rv) i++;
    end
    drain();
    check("rand_words", 64'(n_pop - n0), 64'(10 * RW * WPR));
    check("rand_frames", 64'(n_fd - f0), 64'(10));
    check("rand_ovf", 64'(overflow), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
